fifo_uart_tx: RTL and testbench

Single-clock UART transmitter that drains the read port of a FIFO and serializes each word as an asynchronous serial frame: start bit, LSB-first data, optional parity, one stop bit. It sits on the read side of the UART TX buffer, in the peripheral clock domain. Its FIFO interface expects asynchronous-read (first-word-fall-through) semantics: data is valid whenever the FIFO is not empty. Frames go back-to-back while the FIFO holds data and transmission is enabled.

---
 rtl/fifo_uart_tx.sv | 155 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a first-word-fall-through FIFO and serializes each word as a UART frame.
// Define UART_TX_PARITY_EN to insert a parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  tx_en_i,
   input  logic [DIV_WIDTH-1:0]  baud_div_i,
   input  logic                  parity_odd_i,
   input  logic [DATA_WIDTH-1:0] fifo_data_i,
   input  logic                  fifo_empty_i,
   output logic                  fifo_rd_en_o,
   output logic                  tx_o,
   output logic                  busy_o,
   output logic                  frame_done_o
);

   localparam int BCNT_W = $clog2(DATA_WIDTH) + 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_e;

   state_e                state_q;
   logic [DIV_WIDTH-1:0]  cnt_q;
   logic [DIV_WIDTH-1:0]  period_q;
   logic [BCNT_W-1:0]     bitCnt_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic                  tx_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  bitEnd;
   logic                  stopLast;
   logic                  popEn;

`ifdef UART_TX_PARITY_EN
   logic                  parity_q;
`else
   logic                  parity_unused;
   assign parity_unused = parity_odd_i;
`endif

   // A new word may be popped from IDLE or in the final stop-bit cycle, giving gapless frames.
   assign bitEnd       = (cnt_q == '0);
   assign stopLast     = (state_q == STOP) && bitEnd;
   assign popEn        = tx_en_i && !fifo_empty_i && ((state_q == IDLE) || stopLast);
   assign fifo_rd_en_o = popEn;
   assign tx_o         = tx_q;
   assign busy_o       = busy_q;
   assign frame_done_o = done_q;

   // frame_done is registered, so it is raised one edge early when the next cycle is the last stop cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         period_q <= '0;
         bitCnt_q <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else if (popEn) begin
         state_q  <= START;
         cnt_q    <= baud_div_i;
         period_q <= baud_div_i;
         shift_q  <= fifo_data_i;
         tx_q     <= 1'b0;
         busy_q   <= 1'b1;
         done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= (^fifo_data_i) ^ parity_odd_i;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
            end
            START: begin
               if (bitEnd) begin
                  state_q  <= DATA;
                  cnt_q    <= period_q;
                  tx_q     <= shift_q[0];
                  shift_q  <= shift_q >> 1;
                  bitCnt_q <= BCNT_W'(DATA_WIDTH - 1);
               end else begin
                  cnt_q <= cnt_q - DIV_WIDTH'(1);
               end
            end
            DATA: begin
               if (bitEnd) begin
                  cnt_q <= period_q;
                  if (bitCnt_q == '0) begin
`ifdef UART_TX_PARITY_EN
                     state_q <= PARITY;
                     tx_q    <= parity_q;
`else
                     state_q <= STOP;
                     tx_q    <= 1'b1;
                     done_q  <= (period_q == '0);
`endif
                  end else begin
                     tx_q     <= shift_q[0];
                     shift_q  <= shift_q >> 1;
                     bitCnt_q <= bitCnt_q - BCNT_W'(1);
                  end
               end else begin
                  cnt_q <= cnt_q - DIV_WIDTH'(1);
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bitEnd) begin
                  state_q <= STOP;
                  cnt_q   <= period_q;
                  tx_q    <= 1'b1;
                  done_q  <= (period_q == '0);
               end else begin
                  cnt_q <= cnt_q - DIV_WIDTH'(1);
               end
            end
`endif
            STOP: begin
               if (bitEnd) begin
                  state_q <= IDLE;
                  tx_q    <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q  <= cnt_q - DIV_WIDTH'(1);
                  done_q <= (cnt_q == DIV_WIDTH'(1));
               end
            end
            default: begin
               state_q <= IDLE;
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed self-checking bench for fifo_uart_tx with a small FWFT FIFO model.
// A 4-bit divisor is used so the maximum-divisor frame stays short.
module tb_fifo_uart_tx;

   localparam int DIV_W = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             txEn = 1'b1;
   logic [DIV_W-1:0] baudDiv = '0;
   logic             parityOdd = 1'b0;
   logic [7:0]       fifoData;
   logic             fifoEmpty;
   logic             rdEn;
   logic             tx;
   logic             busy;
   logic             done;

   logic [7:0]       fifoMem [0:15];
   logic [4:0]       wrPtr = '0;
   logic [4:0]       rdPtr = '0;
   int               popCount = 0;
   int               checks = 0;
   int               errors = 0;

   fifo_uart_tx #(.DATA_WIDTH(8), .DIV_WIDTH(DIV_W)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .tx_en_i      (txEn),
      .baud_div_i   (baudDiv),
      .parity_odd_i (parityOdd),
      .fifo_data_i  (fifoData),
      .fifo_empty_i (fifoEmpty),
      .fifo_rd_en_o (rdEn),
      .tx_o         (tx),
      .busy_o       (busy),
      .frame_done_o (done)
   );

   always #5 clk = ~clk;

   // FIFO head is visible combinationally; the read pointer advances on each pop edge.
   assign fifoEmpty = (wrPtr == rdPtr);
   assign fifoData  = fifoMem[rdPtr[3:0]];

   always @(posedge clk) begin
      if (rdEn) begin
         rdPtr    <= rdPtr + 5'd1;
         popCount <= popCount + 1;
      end
   end

   task automatic pushWord(input logic [7:0] w);
      fifoMem[wrPtr[3:0]] = w;
      wrPtr = wrPtr + 5'd1;
   endtask

   // Expected line level for frame bit idx of word d.
   function automatic logic frameBit(input logic [7:0] d, input int idx, input logic odd);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
      if (idx == 9) return (^d) ^ odd;
`endif
      return 1'b1;
   endfunction

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({tx, busy, done, rdEn} !== 4'b1000) begin
         errors++;
         $display("[TB] FAIL reset_held got %b exp 1000", {tx, busy, done, rdEn});
      end
      rst = 1'b0;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         checks++;
         if ({tx, busy, done, rdEn} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL reset_idle j=%0d got %b exp 1000", j, {tx, busy, done, rdEn});
         end
      end
   endtask

   task automatic test_single_frame();
      int p0;
      logic [3:0] exp;
      p0 = popCount;
      baudDiv = 4'd3;
      pushWord(8'hA5);
      #1;
      checks++;
      if (rdEn !== 1'b1) begin
         errors++;
         $display("[TB] FAIL single_pop_req got %b exp 1", rdEn);
      end
      @(posedge clk);
      for (int j = 0; j < NBITS * 4; j++) begin
         @(negedge clk);
         exp = {frameBit(8'hA5, j / 4, 1'b0), 1'b1, (j == NBITS * 4 - 1), 1'b0};
         checks++;
         if ({tx, busy, done, rdEn} !== exp) begin
            errors++;
            $display("[TB] FAIL single_frame j=%0d got %b exp %b", j, {tx, busy, done, rdEn}, exp);
         end
         if (j == 10) baudDiv = 4'd0;
      end
      @(negedge clk);
      checks++;
      if ({tx, busy, done, rdEn} !== 4'b1000 || popCount - p0 !== 1) begin
         errors++;
         $display("[TB] FAIL single_end got %b pops=%0d exp 1000 pops=1", {tx, busy, done, rdEn}, popCount - p0);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] words [3];
      logic [3:0] exp;
      int p0;
      int w;
      int b;
      words = '{8'h3C, 8'h81, 8'hFF};
      p0 = popCount;
      baudDiv = 4'd0;
      for (int i = 0; i < 3; i++) pushWord(words[i]);
      @(posedge clk);
      for (int j = 0; j < 3 * NBITS; j++) begin
         @(negedge clk);
         w = j / NBITS;
         b = j % NBITS;
         exp = {frameBit(words[w], b, 1'b0), 1'b1, (b == NBITS - 1), (b == NBITS - 1) && (w < 2)};
         checks++;
         if ({tx, busy, done, rdEn} !== exp) begin
            errors++;
            $display("[TB] FAIL b2b j=%0d got %b exp %b", j, {tx, busy, done, rdEn}, exp);
         end
      end
      @(negedge clk);
      checks++;
      if ({tx, busy, done, rdEn} !== 4'b1000 || popCount - p0 !== 3) begin
         errors++;
         $display("[TB] FAIL b2b_end got %b pops=%0d exp 1000 pops=3", {tx, busy, done, rdEn}, popCount - p0);
      end
   endtask

   task automatic test_enable_drop();
      logic [3:0] exp;
      int p0;
      p0 = popCount;
      baudDiv = 4'd1;
      pushWord(8'h96);
      pushWord(8'h4B);
      @(posedge clk);
      for (int j = 0; j < NBITS * 2; j++) begin
         @(negedge clk);
         exp = {frameBit(8'h96, j / 2, 1'b0), 1'b1, (j == NBITS * 2 - 1), 1'b0};
         checks++;
         if ({tx, busy, done, rdEn} !== exp) begin
            errors++;
            $display("[TB] FAIL endrop j=%0d got %b exp %b", j, {tx, busy, done, rdEn}, exp);
         end
         if (j == 5) txEn = 1'b0;
      end
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         checks++;
         if ({tx, busy, done, rdEn} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL endrop_idle j=%0d got %b exp 1000", j, {tx, busy, done, rdEn});
         end
      end
      checks++;
      if (popCount - p0 !== 1) begin
         errors++;
         $display("[TB] FAIL endrop_pops got %0d exp 1", popCount - p0);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [3:0] exp;
      int p0;
      p0 = popCount;
      baudDiv = 4'd1;
      pushWord(8'hE1);
      txEn = 1'b1;
      @(posedge clk);
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         exp = {frameBit(8'h4B, j / 2, 1'b0), 1'b1, 1'b0, 1'b0};
         checks++;
         if ({tx, busy, done, rdEn} !== exp) begin
            errors++;
            $display("[TB] FAIL rstmid_pre j=%0d got %b exp %b", j, {tx, busy, done, rdEn}, exp);
         end
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({tx, busy, done} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL rstmid_async got %b exp 100", {tx, busy, done});
      end
      txEn = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if ({tx, busy, done, rdEn} !== 4'b1000) begin
         errors++;
         $display("[TB] FAIL rstmid_release got %b exp 1000", {tx, busy, done, rdEn});
      end
      @(negedge clk);
      txEn = 1'b1;
      #1;
      checks++;
      if (rdEn !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rstmid_repop got %b exp 1", rdEn);
      end
      @(posedge clk);
      for (int j = 0; j < NBITS * 2; j++) begin
         @(negedge clk);
         exp = {frameBit(8'hE1, j / 2, 1'b0), 1'b1, (j == NBITS * 2 - 1), 1'b0};
         checks++;
         if ({tx, busy, done, rdEn} !== exp) begin
            errors++;
            $display("[TB] FAIL rstmid_frame j=%0d got %b exp %b", j, {tx, busy, done, rdEn}, exp);
         end
      end
      @(negedge clk);
      checks++;
      if ({tx, busy, done, rdEn} !== 4'b1000 || popCount - p0 !== 2) begin
         errors++;
         $display("[TB] FAIL rstmid_end got %b pops=%0d exp 1000 pops=2", {tx, busy, done, rdEn}, popCount - p0);
      end
   endtask

   task automatic test_max_divisor();
      logic [3:0] exp;
      baudDiv = 4'hF;
      pushWord(8'hC3);
      @(posedge clk);
      for (int j = 0; j < NBITS * 16; j++) begin
         @(negedge clk);
         exp = {frameBit(8'hC3, j / 16, 1'b0), 1'b1, (j == NBITS * 16 - 1), 1'b0};
         checks++;
         if ({tx, busy, done, rdEn} !== exp) begin
            errors++;
            $display("[TB] FAIL maxdiv j=%0d got %b exp %b", j, {tx, busy, done, rdEn}, exp);
         end
      end
      @(negedge clk);
      checks++;
      if ({tx, busy, done, rdEn} !== 4'b1000) begin
         errors++;
         $display("[TB] FAIL maxdiv_end got %b exp 1000", {tx, busy, done, rdEn});
      end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      logic [3:0] exp;
      logic       expPar;
      baudDiv = 4'd0;
      parityOdd = 1'b0;
      pushWord(8'h07);
      pushWord(8'h07);
      @(posedge clk);
      for (int j = 0; j < 2 * NBITS; j++) begin
         @(negedge clk);
         if (j == 0) parityOdd = 1'b1;
         exp = {frameBit(8'h07, j % NBITS, (j >= NBITS)), 1'b1, (j % NBITS == NBITS - 1),
                (j == NBITS - 1)};
         checks++;
         if ({tx, busy, done, rdEn} !== exp) begin
            errors++;
            $display("[TB] FAIL parity j=%0d got %b exp %b", j, {tx, busy, done, rdEn}, exp);
         end
         if (j % NBITS == 9) begin
            expPar = (j < NBITS) ? 1'b1 : 1'b0;
            checks++;
            if (tx !== expPar) begin
               errors++;
               $display("[TB] FAIL parity_bit j=%0d got %b exp %b", j, tx, expPar);
            end
         end
      end
      parityOdd = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_enable_drop();
      test_reset_mid_frame();
      test_max_divisor();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
